// File: rtl/aes_ram_seq_pkg.sv
// Shared definitions for the AES RAM sequencer: AES core register map, control/status bits, FSM states.
package aes_ram_seq_pkg;

  localparam logic [7:0] AES_CTRL    = 8'h08;
  localparam logic [7:0] AES_STATUS  = 8'h09;
  localparam logic [7:0] AES_CONFIG  = 8'h0A;
  localparam logic [7:0] AES_KEY0    = 8'h10;
  localparam logic [7:0] AES_BLOCK0  = 8'h20;
  localparam logic [7:0] AES_RESULT0 = 8'h30;

  localparam int CTRL_INIT_BIT    = 0;
  localparam int CTRL_NEXT_BIT    = 1;
  localparam int STATUS_READY_BIT = 0;
  localparam int STATUS_VALID_BIT = 1;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_CFG,
    ST_KEY_RD,
    ST_KEY_WAIT,
    ST_KEY_WR,
    ST_INIT,
    ST_POLL_RDY,
    ST_RDY_CHK,
    ST_BLK_RD,
    ST_BLK_WAIT,
    ST_BLK_WR,
    ST_NEXT,
    ST_POLL_VLD,
    ST_VLD_CHK,
    ST_RES_RD,
    ST_RES_CAP,
    ST_RES_WR,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/aes_ram_seq_wb_word_rd.sv
// Single-word pipelined Wishbone read: one request in, one strobe out, data and valid pulse on ack.
module wb_word_rd #(
  parameter int ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [31:0]       data_o,
  output logic              valid_o,
  output logic              cyc_o,
  output logic              stb_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [31:0]       data_i,
  input  logic              ack_i,
  input  logic              stall_i
);

  logic              cyc_q;
  logic              stb_q;
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!cyc_q) begin
        if (req_i) begin
          cyc_q <= 1'b1;
          stb_q <= 1'b1;
        end
      end else begin
        if (stb_q && !stall_i) stb_q <= 1'b0;
        // An ack closes the cycle even if it lands on the accepting cycle.
        if (ack_i) begin
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          valid_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!cyc_q && req_i) addr_q <= addr_i;
    if (cyc_q && ack_i)  data_q <= data_i;
  end

  assign cyc_o   = cyc_q;
  assign stb_o   = stb_q;
  assign addr_o  = cyc_q ? addr_q : '0;
  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/aes_ram_seq.sv
// Multi-block AES sequencer: loads key from RAM, streams blocks RAM -> AES core -> result port.
module aes_ram_seq
  import aes_ram_seq_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int MAX_BLOCKS   = 32,
  parameter int KEY_BASE     = 0,
  parameter int SRC_BASE     = 16,
  parameter int DST_BASE     = 256,
  parameter int POLL_TIMEOUT = 1024,
  localparam int CW          = $clog2(MAX_BLOCKS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              encdec_i,
  input  logic              keylen_i,
  input  logic [CW-1:0]     num_blocks_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              ram_cyc_o,
  output logic              ram_stb_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [31:0]       ram_data_i,
  input  logic              ram_ack_i,
  input  logic              ram_stall_i,
  output logic              wr_we_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  input  logic              wr_ack_i,
  output logic              aes_cs_o,
  output logic              aes_we_o,
  output logic [7:0]        aes_address_o,
  output logic [31:0]       aes_write_data_o,
  input  logic [31:0]       aes_read_data_i
);

  localparam int PW = $clog2(POLL_TIMEOUT + 1);

  function automatic logic [CW-1:0] clamp_blocks(input logic [CW-1:0] n);
    if (n > CW'(MAX_BLOCKS)) return CW'(MAX_BLOCKS);
    return n;
  endfunction

  state_e        state_q, state_d;
  logic [2:0]    word_q, word_d;
  logic [CW-1:0] blk_q, blk_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [CW-1:0] nblk_q;
  logic          encdec_q;
  logic          keylen_q;
  logic [31:0]   res_q;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_vld;
  logic [2:0]        key_last;
  logic [ADDR_W-1:0] key_addr;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;

  assign key_last = keylen_q ? 3'd7 : 3'd3;
  assign key_addr = ADDR_W'(KEY_BASE) + ADDR_W'(word_q);
  assign src_addr = ADDR_W'(SRC_BASE) + (ADDR_W'(blk_q) << 2) + ADDR_W'(word_q[1:0]);
  assign dst_addr = ADDR_W'(DST_BASE) + (ADDR_W'(blk_q) << 2) + ADDR_W'(word_q[1:0]);
  assign rd_addr  = (state_q == ST_KEY_RD) ? key_addr : src_addr;

  wb_word_rd #(.ADDR_W(ADDR_W)) u_rd (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (rd_req),
    .addr_i  (rd_addr),
    .data_o  (rd_data),
    .valid_o (rd_vld),
    .cyc_o   (ram_cyc_o),
    .stb_o   (ram_stb_o),
    .addr_o  (ram_addr_o),
    .data_i  (ram_data_i),
    .ack_i   (ram_ack_i),
    .stall_i (ram_stall_i)
  );

  assign ram_we_o = 4'b0000;
  assign busy_o   = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});

  always_comb begin
    state_d          = state_q;
    word_d           = word_q;
    blk_d            = blk_q;
    poll_d           = poll_q;
    rd_req           = 1'b0;
    aes_cs_o         = 1'b0;
    aes_we_o         = 1'b0;
    aes_address_o    = '0;
    aes_write_data_o = '0;
    wr_we_o          = 1'b0;
    wr_addr_o        = '0;
    wr_data_o        = '0;
    done_o           = 1'b0;
    error_o          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CFG;
          word_d  = '0;
          blk_d   = '0;
          poll_d  = '0;
        end
      end
      ST_CFG: begin
        aes_cs_o         = 1'b1;
        aes_we_o         = 1'b1;
        aes_address_o    = AES_CONFIG;
        aes_write_data_o = {30'b0, keylen_q, encdec_q};
        state_d          = ST_KEY_RD;
      end
      ST_KEY_RD: begin
        rd_req  = 1'b1;
        state_d = ST_KEY_WAIT;
      end
      ST_KEY_WAIT: if (rd_vld) state_d = ST_KEY_WR;
      ST_KEY_WR: begin
        aes_cs_o         = 1'b1;
        aes_we_o         = 1'b1;
        aes_address_o    = AES_KEY0 + 8'(word_q);
        aes_write_data_o = rd_data;
        if (word_q == key_last) begin
          word_d  = '0;
          state_d = ST_INIT;
        end else begin
          word_d  = word_q + 3'd1;
          state_d = ST_KEY_RD;
        end
      end
      ST_INIT: begin
        aes_cs_o         = 1'b1;
        aes_we_o         = 1'b1;
        aes_address_o    = AES_CTRL;
        aes_write_data_o = 32'(1) << CTRL_INIT_BIT;
        poll_d           = '0;
        state_d          = ST_POLL_RDY;
      end
      ST_POLL_RDY: begin
        aes_cs_o      = 1'b1;
        aes_address_o = AES_STATUS;
        poll_d        = poll_q + PW'(1);
        state_d       = ST_RDY_CHK;
      end
      ST_RDY_CHK: begin
        if (aes_read_data_i[STATUS_READY_BIT]) begin
          word_d  = '0;
          blk_d   = '0;
          state_d = (nblk_q == '0) ? ST_DONE : ST_BLK_RD;
        end else if (poll_q == PW'(POLL_TIMEOUT)) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_POLL_RDY;
        end
      end
      ST_BLK_RD: begin
        rd_req  = 1'b1;
        state_d = ST_BLK_WAIT;
      end
      ST_BLK_WAIT: if (rd_vld) state_d = ST_BLK_WR;
      ST_BLK_WR: begin
        aes_cs_o         = 1'b1;
        aes_we_o         = 1'b1;
        aes_address_o    = AES_BLOCK0 + 8'(word_q[1:0]);
        aes_write_data_o = rd_data;
        if (word_q[1:0] == 2'd3) begin
          word_d  = '0;
          state_d = ST_NEXT;
        end else begin
          word_d  = word_q + 3'd1;
          state_d = ST_BLK_RD;
        end
      end
      ST_NEXT: begin
        aes_cs_o         = 1'b1;
        aes_we_o         = 1'b1;
        aes_address_o    = AES_CTRL;
        aes_write_data_o = 32'(1) << CTRL_NEXT_BIT;
        poll_d           = '0;
        state_d          = ST_POLL_VLD;
      end
      ST_POLL_VLD: begin
        aes_cs_o      = 1'b1;
        aes_address_o = AES_STATUS;
        poll_d        = poll_q + PW'(1);
        state_d       = ST_VLD_CHK;
      end
      ST_VLD_CHK: begin
        if (aes_read_data_i[STATUS_VALID_BIT]) begin
          word_d  = '0;
          state_d = ST_RES_RD;
        end else if (poll_q == PW'(POLL_TIMEOUT)) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_POLL_VLD;
        end
      end
      ST_RES_RD: begin
        aes_cs_o      = 1'b1;
        aes_address_o = AES_RESULT0 + 8'(word_q[1:0]);
        state_d       = ST_RES_CAP;
      end
      ST_RES_CAP: state_d = ST_RES_WR;
      ST_RES_WR: begin
        wr_we_o   = 1'b1;
        wr_addr_o = dst_addr;
        wr_data_o = res_q;
        if (wr_ack_i) begin
          if (word_q[1:0] == 2'd3) begin
            word_d = '0;
            if (blk_q == nblk_q - CW'(1)) begin
              state_d = ST_DONE;
            end else begin
              blk_d   = blk_q + CW'(1);
              state_d = ST_BLK_RD;
            end
          end else begin
            word_d  = word_q + 3'd1;
            state_d = ST_RES_RD;
          end
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        error_o = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      blk_q    <= '0;
      poll_q   <= '0;
      nblk_q   <= '0;
      encdec_q <= 1'b0;
      keylen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      blk_q   <= blk_d;
      poll_q  <= poll_d;
      if (state_q == ST_IDLE && start_i) begin
        nblk_q   <= clamp_blocks(num_blocks_i);
        encdec_q <= encdec_i;
        keylen_q <= keylen_i;
      end
    end
  end

  // AES read data is only valid the cycle after the RESULT access.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_RES_CAP) res_q <= aes_read_data_i;
  end

endmodule

// File: tb/tb_aes_ram_seq.sv
// Directed bench for aes_ram_seq with RAM, AES-core and result-port models.
module tb_aes_ram_seq;
  localparam int ADDR_W = 9;
  localparam int CW     = 6;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic              encdec_i = 1'b0;
  logic              keylen_i = 1'b0;
  logic [CW-1:0]     num_blocks_i = '0;
  logic              busy_o, done_o, error_o;
  logic              ram_cyc_o, ram_stb_o;
  logic [3:0]        ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_data_i;
  logic              ram_ack_i, ram_stall_i;
  logic              wr_we_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;
  logic              wr_ack_i;
  logic              aes_cs_o, aes_we_o;
  logic [7:0]        aes_address_o;
  logic [31:0]       aes_write_data_o;
  logic [31:0]       aes_read_data_i = '0;

  aes_ram_seq #(.ADDR_W(ADDR_W), .MAX_BLOCKS(32), .KEY_BASE(0), .SRC_BASE(16),
                .DST_BASE(256), .POLL_TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .encdec_i(encdec_i),
    .keylen_i(keylen_i), .num_blocks_i(num_blocks_i), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .ram_cyc_o(ram_cyc_o), .ram_stb_o(ram_stb_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_i(ram_data_i),
    .ram_ack_i(ram_ack_i), .ram_stall_i(ram_stall_i), .wr_we_o(wr_we_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_ack_i(wr_ack_i),
    .aes_cs_o(aes_cs_o), .aes_we_o(aes_we_o), .aes_address_o(aes_address_o),
    .aes_write_data_o(aes_write_data_o), .aes_read_data_i(aes_read_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Model controls and statistics
  logic clr = 1'b0;
  bit   stall_mode = 1'b0;
  int   ram_lat = 1;
  int   wr_lat = 0;
  bit   vld_en = 1'b1;

  int st_cnt = 0, ack_dly = 0, acc_cnt = 0, stall_seen = 0, we_bad = 0;
  logic [ADDR_W-1:0] acc_addr = '0;
  int cfg_cnt = 0, init_cnt = 0, next_cnt = 0, key_cnt = 0, blk_cnt = 0;
  int stat_rd = 0, res_rd = 0, wr_cnt = 0, wr_unstable = 0, wr_wait = 0;
  int done_cnt = 0, err_cnt = 0;
  logic [31:0] cfg_data = '0;
  logic [31:0] key_data [8];
  logic [31:0] blk_reg [4];
  logic [31:0] res_mem [8];
  logic [ADDR_W-1:0] wr_addr_prev = '0;
  logic [31:0] wr_data_prev = '0;

  // RAM: word at address a is 0x1000_0000 + a
  assign ram_stall_i = stall_mode && ram_stb_o && (st_cnt < 3);
  assign ram_ack_i   = (ack_dly == 1);
  assign ram_data_i  = 32'h1000_0000 + 32'(acc_addr);

  always @(posedge clk_i) begin
    if (ram_cyc_o && ram_stb_o && !ram_stall_i) begin
      st_cnt   <= 0;
      ack_dly  <= ram_lat;
      acc_addr <= ram_addr_o;
    end else if (ack_dly != 0) begin
      ack_dly <= ack_dly - 1;
    end
    if (ram_stb_o && ram_stall_i) st_cnt <= st_cnt + 1;
    if (clr) begin
      acc_cnt <= 0; stall_seen <= 0; we_bad <= 0;
    end else begin
      if (ram_cyc_o && ram_stb_o && !ram_stall_i) acc_cnt <= acc_cnt + 1;
      if (ram_stb_o && ram_stall_i) stall_seen <= stall_seen + 1;
      if (ram_we_o != 4'b0) we_bad <= we_bad + 1;
    end
  end

  // AES core: results are the block words XOR 0x5A5A5A5A
  always @(posedge clk_i) begin
    if (aes_cs_o && !aes_we_o) begin
      if (aes_address_o == 8'h09) aes_read_data_i <= {30'b0, vld_en, 1'b1};
      else if (aes_address_o[7:2] == 6'b001100) aes_read_data_i <= blk_reg[aes_address_o[1:0]] ^ 32'h5A5A_5A5A;
      else aes_read_data_i <= '0;
    end
    if (aes_cs_o && aes_we_o && aes_address_o[7:2] == 6'b001000) blk_reg[aes_address_o[1:0]] <= aes_write_data_o;
    if (clr) begin
      cfg_cnt <= 0; init_cnt <= 0; next_cnt <= 0; key_cnt <= 0; blk_cnt <= 0;
      stat_rd <= 0; res_rd <= 0; cfg_data <= '0;
      for (int i = 0; i < 8; i++) key_data[i] <= '0;
    end else if (aes_cs_o && aes_we_o) begin
      if (aes_address_o == 8'h0A) begin
        cfg_cnt <= cfg_cnt + 1; cfg_data <= aes_write_data_o;
      end else if (aes_address_o == 8'h08) begin
        if (aes_write_data_o == 32'h1) init_cnt <= init_cnt + 1;
        if (aes_write_data_o == 32'h2) next_cnt <= next_cnt + 1;
      end else if (aes_address_o[7:3] == 5'b00010) begin
        key_cnt <= key_cnt + 1; key_data[aes_address_o[2:0]] <= aes_write_data_o;
      end else if (aes_address_o[7:2] == 6'b001000) begin
        blk_cnt <= blk_cnt + 1;
      end
    end else if (aes_cs_o) begin
      if (aes_address_o == 8'h09) stat_rd <= stat_rd + 1;
      if (aes_address_o[7:2] == 6'b001100) res_rd <= res_rd + 1;
    end
  end

  // Result port with optional ack delay; also pulse counters
  assign wr_ack_i = wr_we_o && (wr_wait >= wr_lat);

  always @(posedge clk_i) begin
    wr_addr_prev <= wr_addr_o;
    wr_data_prev <= wr_data_o;
    if (wr_we_o && !wr_ack_i) wr_wait <= wr_wait + 1;
    else wr_wait <= 0;
    if (clr) begin
      wr_cnt <= 0; wr_unstable <= 0; done_cnt <= 0; err_cnt <= 0;
      for (int i = 0; i < 8; i++) res_mem[i] <= '0;
    end else begin
      if (wr_we_o && wr_wait != 0 && (wr_addr_o != wr_addr_prev || wr_data_o != wr_data_prev))
        wr_unstable <= wr_unstable + 1;
      if (wr_we_o && wr_ack_i) begin
        wr_cnt <= wr_cnt + 1;
        if (wr_addr_o >= 9'd256 && wr_addr_o < 9'd264) res_mem[wr_addr_o - 9'd256] <= wr_data_o;
      end
      if (done_o) done_cnt <= done_cnt + 1;
      if (error_o) err_cnt <= err_cnt + 1;
    end
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    @(negedge clk_i); clr = 1'b1;
    @(negedge clk_i); clr = 1'b0;
  endtask

  task automatic start_run(input bit kl, input bit ed, input logic [CW-1:0] n);
    @(negedge clk_i);
    keylen_i = kl; encdec_i = ed; num_blocks_i = n; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_i);
      if (done_o || error_o) begin ok = 1'b1; break; end
    end
    chk({tag, "_finished_in_time"}, 64'(ok), 64'd1);
    repeat (3) @(negedge clk_i);
  endtask

  function automatic logic [31:0] exp_res(input int b, input int w);
    return (32'h1000_0000 + 32'(16 + 4 * b + w)) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk_outputs_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_pulses"}, 64'({done_o, error_o}), 64'd0);
    chk({tag, "_ram_bus"}, 64'({ram_cyc_o, ram_stb_o, ram_we_o, ram_addr_o}), 64'd0);
    chk({tag, "_aes_bus"}, 64'({aes_cs_o, aes_we_o, aes_address_o, aes_write_data_o}), 64'd0);
    chk({tag, "_wr_bus"}, 64'({wr_we_o, wr_addr_o, wr_data_o}), 64'd0);
  endtask

  initial begin
    bit seen;
    // Reset state
    repeat (3) @(negedge clk_i);
    chk_outputs_idle("reset");
    rst_ni = 1'b1;
    clear_stats();

    // 1: 256-bit key, encrypt, two blocks, zero-wait
    start_run(1'b1, 1'b1, 6'd2);
    chk("t1_busy_after_start", 64'(busy_o), 64'd1);
    wait_end("t1", 2000);
    chk("t1_key_writes", 64'(key_cnt), 64'd8);
    for (int k = 0; k < 8; k++) chk($sformatf("t1_key%0d", k), 64'(key_data[k]), 64'(32'h1000_0000 + 32'(k)));
    chk("t1_cfg", 64'(cfg_data), 64'h3);
    chk("t1_init_next", 64'({init_cnt[7:0], next_cnt[7:0]}), 64'h0102);
    chk("t1_blk_writes", 64'(blk_cnt), 64'd8);
    chk("t1_status_reads", 64'(stat_rd), 64'd3);
    chk("t1_wr_count", 64'(wr_cnt), 64'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("t1_res%0d", i), 64'(res_mem[i]), 64'(exp_res(i / 4, i % 4)));
    chk("t1_done_err", 64'({done_cnt[7:0], err_cnt[7:0]}), 64'h0100);
    chk("t1_busy_end", 64'(busy_o), 64'd0);
    chk("t1_ram_we", 64'(we_bad), 64'd0);

    // 2: 128-bit key, one block, result acks delayed
    clear_stats();
    wr_lat = 2;
    start_run(1'b0, 1'b1, 6'd1);
    wait_end("t2", 2000);
    chk("t2_key_writes", 64'(key_cnt), 64'd4);
    chk("t2_cfg", 64'(cfg_data), 64'h1);
    chk("t2_done_pulses", 64'(done_cnt), 64'd1);
    chk("t2_wr_count", 64'(wr_cnt), 64'd4);
    chk("t2_wr_stable", 64'(wr_unstable), 64'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_res%0d", i), 64'(res_mem[i]), 64'(exp_res(0, i)));
    wr_lat = 0;

    // 3: RAM stalls 3 cycles per strobe, ack 2 cycles after acceptance
    clear_stats();
    stall_mode = 1'b1; ram_lat = 2;
    start_run(1'b0, 1'b0, 6'd1);
    wait_end("t3", 3000);
    chk("t3_ram_accepts", 64'(acc_cnt), 64'd8);
    chk("t3_stall_cycles", 64'(stall_seen), 64'd24);
    chk("t3_cfg", 64'(cfg_data), 64'h0);
    for (int k = 0; k < 4; k++) chk($sformatf("t3_key%0d", k), 64'(key_data[k]), 64'(32'h1000_0000 + 32'(k)));
    for (int i = 0; i < 4; i++) chk($sformatf("t3_res%0d", i), 64'(res_mem[i]), 64'(exp_res(0, i)));
    chk("t3_done_pulses", 64'(done_cnt), 64'd1);
    stall_mode = 1'b0; ram_lat = 1;

    // 4: valid never set -> timeout after 16 STATUS reads
    clear_stats();
    vld_en = 1'b0;
    start_run(1'b0, 1'b1, 6'd1);
    wait_end("t4", 2000);
    chk("t4_status_reads", 64'(stat_rd), 64'd17);
    chk("t4_done_err", 64'({done_cnt[7:0], err_cnt[7:0]}), 64'h0001);
    chk("t4_res_reads", 64'(res_rd), 64'd0);
    chk("t4_busy_end", 64'(busy_o), 64'd0);
    vld_en = 1'b1;

    // 5: zero blocks; a second start while busy is ignored
    clear_stats();
    start_run(1'b0, 1'b1, 6'd0);
    repeat (4) @(negedge clk_i);
    chk("t5_busy_mid", 64'(busy_o), 64'd1);
    start_run(1'b1, 1'b1, 6'd2);
    wait_end("t5", 2000);
    chk("t5_key_writes", 64'(key_cnt), 64'd4);
    chk("t5_init", 64'(init_cnt), 64'd1);
    chk("t5_block_result", 64'({blk_cnt[7:0], res_rd[7:0], wr_cnt[7:0], next_cnt[7:0]}), 64'd0);
    repeat (20) @(negedge clk_i);
    chk("t5_no_rerun", 64'({busy_o, done_cnt[7:0], cfg_cnt[7:0]}), 64'h00101);

    // Block count above MAX_BLOCKS clamps to 32
    clear_stats();
    start_run(1'b0, 1'b1, 6'd40);
    wait_end("clamp", 8000);
    chk("clamp_wr_count", 64'(wr_cnt), 64'd128);
    chk("clamp_next", 64'(next_cnt), 64'd32);

    // 6: asynchronous reset during a block read, then a clean run
    clear_stats();
    stall_mode = 1'b1; ram_lat = 2;
    start_run(1'b0, 1'b1, 6'd2);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_i);
      if (ram_stb_o && ram_addr_o >= 9'd16) begin seen = 1'b1; break; end
    end
    chk("t6_reached_blk_rd", 64'(seen), 64'd1);
    #2 rst_ni = 1'b0;
    #1 chk_outputs_idle("t6_async");
    @(negedge clk_i);
    stall_mode = 1'b0; ram_lat = 1;
    rst_ni = 1'b1;
    clear_stats();
    start_run(1'b0, 1'b0, 6'd1);
    wait_end("t6", 2000);
    chk("t6_done_err", 64'({done_cnt[7:0], err_cnt[7:0]}), 64'h0100);
    for (int i = 0; i < 4; i++) chk($sformatf("t6_res%0d", i), 64'(res_mem[i]), 64'(exp_res(0, i)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
